// File: rtl/ibex_pkg.sv
// Shared types and helpers for the IF-stage fetch buffer and aligner.
package ibex_pkg;

    localparam int unsigned FETCH_FIFO_MAX_DEPTH = 8;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } fetch_entry_t;

    // RISC-V encodes 32-bit instructions with 2'b11 in the two lowest bits.
    function automatic logic is_compressed(input logic [1:0] lsb);
        return lsb != 2'b11;
    endfunction

endpackage

// File: rtl/ibex_fetch_aligner.sv
// Combinational aligner: picks a halfword-aligned instruction out of the two
// lowest buffer entries and attributes fetch errors to it.
module ibex_fetch_aligner
    import ibex_pkg::*;
(
    input  fetch_entry_t entry0,
    input  fetch_entry_t entry1,
    input  logic [1:0]   valid,
    input  logic         addr_bit1,
    output logic         out_valid,
    output logic [31:0]  out_rdata,
    output logic         out_err,
    output logic         out_err_plus2,
    output logic         compressed,
    output logic         pop0
);

    logic [15:0] unused_entry1_hi;
    assign unused_entry1_hi = entry1.rdata[31:16];

    // An erroneous first half is reported even without its second half, so
    // the core can take the fault instead of waiting for a word that never comes.
    always_comb begin
        out_valid     = valid[0];
        out_rdata     = entry0.rdata;
        out_err       = entry0.err;
        out_err_plus2 = 1'b0;
        if (addr_bit1) begin
            if (is_compressed(entry0.rdata[17:16])) begin
                out_rdata = {16'h0000, entry0.rdata[31:16]};
            end else begin
                out_valid     = valid[1] | (valid[0] & entry0.err);
                out_rdata     = {entry1.rdata[15:0], entry0.rdata[31:16]};
                out_err       = entry0.err | (valid[1] & entry1.err);
                out_err_plus2 = ~entry0.err & entry1.err;
            end
        end
    end

    assign compressed = is_compressed(out_rdata[1:0]);
    // Only an aligned compressed instruction leaves the upper half of entry0 to use.
    assign pop0       = addr_bit1 | ~compressed;

endmodule

// File: rtl/ibex_fetch_align_fifo.sv
// IF-stage fetch buffer with halfword aligner.
// Optional macro IBEX_FETCH_FIFO_BYPASS_EN: feed the returning word straight to the aligner.
module ibex_fetch_align_fifo
    import ibex_pkg::*;
#(
    parameter int unsigned DEPTH = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic [31:0] addr_i,
    input  logic        in_valid_i,
    input  logic [31:0] in_rdata_i,
    input  logic        in_err_i,
    output logic        busy_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_rdata_o,
    output logic [31:0] out_addr_o,
    output logic        out_err_o,
    output logic        out_err_plus2_o
);

    fetch_entry_t     entries   [DEPTH];
    fetch_entry_t     entries_n [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] valid_n;
    logic [31:1]      addr_q;

    fetch_entry_t in_entry;
    fetch_entry_t align_e0;
    fetch_entry_t align_e1;
    logic [1:0]   align_valid;
    logic         compressed;
    logic         pop0;
    logic         accept;
    logic         pop;
    logic         push_en;
    logic         unused_addr_bit0;

    assign unused_addr_bit0 = addr_i[0];
    assign in_entry         = {in_err_i, in_rdata_i};

`ifdef IBEX_FETCH_FIFO_BYPASS_EN
    // The incoming word stands in for whichever slot the aligner is missing.
    always_comb begin
        align_e0    = entries[0];
        align_e1    = entries[1];
        align_valid = valid[1:0];
        if (!valid[0]) begin
            align_e0       = in_entry;
            align_valid[0] = in_valid_i;
        end else if (!valid[1]) begin
            align_e1       = in_entry;
            align_valid[1] = in_valid_i;
        end
    end
`else
    assign align_e0    = entries[0];
    assign align_e1    = entries[1];
    assign align_valid = valid[1:0];
`endif

    ibex_fetch_aligner u_aligner (
        .entry0        (align_e0),
        .entry1        (align_e1),
        .valid         (align_valid),
        .addr_bit1     (addr_q[1]),
        .out_valid     (out_valid_o),
        .out_rdata     (out_rdata_o),
        .out_err       (out_err_o),
        .out_err_plus2 (out_err_plus2_o),
        .compressed    (compressed),
        .pop0          (pop0)
    );

    assign out_addr_o = {addr_q, 1'b0};
    assign accept     = out_valid_o & out_ready_i & ~clear_i;
    assign pop        = accept & pop0;
    // A pop with an empty entry0 can only mean the bypassed word was used up.
    assign push_en    = in_valid_i & ~(pop & ~valid[0]);
    assign busy_o     = valid[DEPTH-2];

    always_comb begin
        logic found;
        found     = 1'b0;
        entries_n = entries;
        valid_n   = valid;
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                entries_n[i] = entries[i+1];
                valid_n[i]   = valid[i+1];
            end
            entries_n[DEPTH-1] = '0;
            valid_n[DEPTH-1]   = 1'b0;
        end
        if (push_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (!found && !valid_n[i]) begin
                    entries_n[i] = in_entry;
                    valid_n[i]   = 1'b1;
                    found        = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid  <= '0;
            addr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (clear_i) begin
            valid  <= '0;
            addr_q <= addr_i[31:1];
        end else begin
            valid   <= valid_n;
            entries <= entries_n;
            if (accept) begin
                addr_q <= addr_q + (compressed ? 31'd1 : 31'd2);
            end
        end
    end

    push_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
        !(push_en && !clear_i && valid[DEPTH-1] && !pop));

endmodule

// File: tb/tb_ibex_fetch_align_fifo.sv
// Self-checking bench for ibex_fetch_align_fifo against a halfword-stream model.
module tb_ibex_fetch_align_fifo;

    localparam int DEPTH = 3;

    logic        clk_i;
    logic        rst_i;
    logic        clear_i;
    logic [31:0] addr_i;
    logic        in_valid_i;
    logic [31:0] in_rdata_i;
    logic        in_err_i;
    logic        busy_o;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_rdata_o;
    logic [31:0] out_addr_o;
    logic        out_err_o;
    logic        out_err_plus2_o;

    ibex_fetch_align_fifo #(.DEPTH(DEPTH)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .clear_i         (clear_i),
        .addr_i          (addr_i),
        .in_valid_i      (in_valid_i),
        .in_rdata_i      (in_rdata_i),
        .in_err_i        (in_err_i),
        .busy_o          (busy_o),
        .out_valid_o     (out_valid_o),
        .out_ready_i     (out_ready_i),
        .out_rdata_o     (out_rdata_o),
        .out_addr_o      (out_addr_o),
        .out_err_o       (out_err_o),
        .out_err_plus2_o (out_err_plus2_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int tests = 0;
    int fails = 0;

    // Reference: stored words as {err, rdata} in arrival order plus the PC.
    logic [32:0] wq[$];
    logic [31:0] maddr;

    logic        exp_valid;
    logic        exp_comp;
    logic        exp_full;
    logic        exp_err;
    logic        exp_plus2;
    logic [31:0] exp_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] halfOf(input logic [32:0] w, input int k);
        return k[0] ? w[31:16] : w[15:0];
    endfunction

    task automatic applyStimulus(input logic r, input logic c, input logic [31:0] a,
                                 input logic iv, input logic [31:0] d, input logic e,
                                 input logic rdy);
        rst_i       = r;
        clear_i     = c;
        addr_i      = a;
        in_valid_i  = iv;
        in_rdata_i  = d;
        in_err_i    = e;
        out_ready_i = rdy;
    endtask

    // Expected instruction from the halfword stream starting at PC bit 1.
    task automatic modelOut();
        logic [32:0] v[$];
        int          k0;
        logic [15:0] h0;
        logic [15:0] h1;
        logic        e0;
        logic        e1;
        v = wq;
`ifdef IBEX_FETCH_FIFO_BYPASS_EN
        if (in_valid_i) v.push_back({in_err_i, in_rdata_i});
`endif
        exp_valid = 1'b0;
        exp_comp  = 1'b0;
        exp_full  = 1'b0;
        exp_err   = 1'b0;
        exp_plus2 = 1'b0;
        exp_rdata = '0;
        k0 = int'(maddr[1]);
        if (v.size() > 0) begin
            h0 = halfOf(v[k0 / 2], k0);
            e0 = v[k0 / 2][32];
            h1 = '0;
            e1 = 1'b0;
            exp_full = ((k0 + 1) / 2) < v.size();
            if (exp_full) begin
                h1 = halfOf(v[(k0 + 1) / 2], k0 + 1);
                e1 = v[(k0 + 1) / 2][32];
            end
            exp_comp = (h0[1:0] != 2'b11);
            if (exp_comp) begin
                exp_valid = 1'b1;
                exp_rdata = {16'h0000, h0};
                exp_err   = e0;
            end else begin
                exp_valid = exp_full | e0;
                exp_rdata = {h1, h0};
                exp_err   = e0 | e1;
                exp_plus2 = ~e0 & e1;
            end
        end
    endtask

    task automatic checkOutput();
        logic [31:0] obs_rdata;
        logic [31:0] want_rdata;
        modelOut();
        chk("busy", 32'(busy_o), 32'(wq.size() >= DEPTH - 1));
        chk("out_valid", 32'(out_valid_o), 32'(exp_valid));
        if (exp_valid) begin
            obs_rdata  = out_rdata_o;
            want_rdata = exp_rdata;
            if (exp_comp || !exp_full) begin
                obs_rdata[31:16]  = '0;
                want_rdata[31:16] = '0;
            end
            chk("out_rdata", obs_rdata, want_rdata);
            chk("out_addr", out_addr_o, maddr);
            chk("out_err", 32'(out_err_o), 32'(exp_err));
            chk("out_err_plus2", 32'(out_err_plus2_o), 32'(exp_plus2));
        end
    endtask

    task automatic tick();
        int n;
        int pos;
        if (rst_i) begin
            wq.delete();
            maddr = '0;
        end else if (clear_i) begin
            wq.delete();
            maddr = {addr_i[31:1], 1'b0};
        end else begin
            if (in_valid_i) wq.push_back({in_err_i, in_rdata_i});
            if (exp_valid && out_ready_i) begin
                n   = exp_comp ? 1 : 2;
                pos = int'(maddr[1]) + n;
                repeat (pos / 2) void'(wq.pop_front());
                maddr = maddr + 32'(2 * n);
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic step(input logic r, input logic c, input logic [31:0] a, input logic iv,
                        input logic [31:0] d, input logic e, input logic rdy);
        applyStimulus(r, c, a, iv, d, e, rdy);
        #2;
        checkOutput();
    endtask

    task automatic cycle(input logic r, input logic c, input logic [31:0] a, input logic iv,
                         input logic [31:0] d, input logic e, input logic rdy);
        step(r, c, a, iv, d, e, rdy);
        tick();
    endtask

    task automatic checkAllZero(input string tag);
        chk({tag, "_valid"}, 32'(out_valid_o), 32'd0);
        chk({tag, "_rdata"}, out_rdata_o, 32'd0);
        chk({tag, "_addr"}, out_addr_o, 32'd0);
        chk({tag, "_err"}, 32'(out_err_o), 32'd0);
        chk({tag, "_plus2"}, 32'(out_err_plus2_o), 32'd0);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        maddr = '0;
        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        tick();
        tick();

        step(0, 0, 0, 0, 0, 0, 0);
        checkAllZero("reset");
        tick();

        // Two aligned 32-bit instructions.
        cycle(0, 1, 32'h80, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 32'h0000_0013, 0, 0);
        cycle(0, 0, 0, 1, 32'h00A0_0093, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("aligned_busy", 32'(busy_o), 32'd1);
        chk("aligned0_valid", 32'(out_valid_o), 32'd1);
        chk("aligned0_rdata", out_rdata_o, 32'h0000_0013);
        chk("aligned0_addr", out_addr_o, 32'h80);
        tick();
        step(0, 0, 0, 0, 0, 0, 1);
        chk("aligned1_rdata", out_rdata_o, 32'h00A0_0093);
        chk("aligned1_addr", out_addr_o, 32'h84);
        tick();
        cycle(0, 0, 0, 0, 0, 0, 1);

        // Unaligned compressed, then aligned compressed.
        cycle(0, 1, 32'h102, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 32'h4505_1234, 0, 0);
        cycle(0, 0, 0, 1, 32'h0000_0001, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("cli_rdata", {16'h0, out_rdata_o[15:0]}, 32'h4505);
        chk("cli_addr", out_addr_o, 32'h102);
        tick();
        step(0, 0, 0, 0, 0, 0, 1);
        chk("cnop_valid", 32'(out_valid_o), 32'd1);
        chk("cnop_rdata", {16'h0, out_rdata_o[15:0]}, 32'h0001);
        chk("cnop_addr", out_addr_o, 32'h104);
        tick();

        // Straddle waits for its second word.
        cycle(0, 1, 32'h202, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 32'h0093_1111, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 0, 1);
            chk("straddle_wait", 32'(out_valid_o), 32'd0);
            tick();
        end
        cycle(0, 0, 0, 1, 32'hABCD_00A0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("straddle_rdata", out_rdata_o, 32'h00A0_0093);
        chk("straddle_addr", out_addr_o, 32'h202);
        tick();

        // Error only in the second word of a straddle.
        cycle(0, 1, 32'h302, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 32'h0003_0000, 0, 0);
        cycle(0, 0, 0, 1, 32'h0000_0000, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("err2_err", 32'(out_err_o), 32'd1);
        chk("err2_plus2", 32'(out_err_plus2_o), 32'd1);
        tick();

        // Error in the first word, second word never arrives.
        cycle(0, 1, 32'h402, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 32'h0003_0000, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("err1_valid", 32'(out_valid_o), 32'd1);
        chk("err1_err", 32'(out_err_o), 32'd1);
        chk("err1_plus2", 32'(out_err_plus2_o), 32'd0);
        tick();

        // Clear discards a same-cycle word.
        cycle(0, 1, 32'h501, 1, 32'h0000_0001, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("clear_valid", 32'(out_valid_o), 32'd0);
        chk("clear_addr", out_addr_o, 32'h500);
        tick();

        // Reset in the middle of a straddle.
        cycle(0, 1, 32'h602, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 32'h0013_0001, 0, 0);
        cycle(0, 0, 0, 1, 32'h0001_0000, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        checkAllZero("midreset");
        tick();

`ifdef IBEX_FETCH_FIFO_BYPASS_EN
        cycle(0, 1, 32'h700, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'h0000_4505, 0, 1);
        chk("bypass_valid", 32'(out_valid_o), 32'd1);
        chk("bypass_rdata", {16'h0, out_rdata_o[15:0]}, 32'h4505);
        tick();
`endif

        // Random traffic against the model.
        for (int i = 0; i < 800; i++) begin
            d = $urandom;
            if ($urandom_range(0, 1) == 0) d[1:0] = 2'b11;
            if ($urandom_range(0, 1) == 0) d[17:16] = 2'b11;
            cycle($urandom_range(0, 149) == 0,
                  $urandom_range(0, 24) == 0,
                  $urandom,
                  (wq.size() < DEPTH) && ($urandom_range(0, 2) != 0),
                  d,
                  $urandom_range(0, 11) == 0,
                  $urandom_range(0, 3) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
